// File: rtl/aes_avb_pkg.sv
// Shared constants for the AES Avalon block bridge: register map and the
// bit positions of the CTRL and STATUS registers.
package aes_avb_pkg;

    typedef enum logic [1:0] {
        AddrCtrl    = 2'd0,
        AddrStatus  = 2'd1,
        AddrDataIn  = 2'd2,
        AddrDataOut = 2'd3
    } reg_addr_e;

    localparam int unsigned CtrlClrBit   = 0;
    localparam int unsigned CtrlIrqEnBit = 1;

    localparam int unsigned StInFullBit   = 0;
    localparam int unsigned StInEmptyBit  = 1;
    localparam int unsigned StOutFullBit  = 2;
    localparam int unsigned StOutEmptyBit = 3;
    localparam int unsigned StOvfBit      = 4;
    localparam int unsigned StUnfBit      = 5;
    localparam int unsigned StInCntLsb    = 8;
    localparam int unsigned StOutCntLsb   = 16;

    function automatic logic [31:0] pack_status(
        input logic       in_full,
        input logic       in_empty,
        input logic       out_full,
        input logic       out_empty,
        input logic       ovf,
        input logic       unf,
        input logic [7:0] in_cnt,
        input logic [7:0] out_cnt
    );
        logic [31:0] s;
        s                    = '0;
        s[StInFullBit]       = in_full;
        s[StInEmptyBit]      = in_empty;
        s[StOutFullBit]      = out_full;
        s[StOutEmptyBit]     = out_empty;
        s[StOvfBit]          = ovf;
        s[StUnfBit]          = unf;
        s[StInCntLsb +: 8]   = in_cnt;
        s[StOutCntLsb +: 8]  = out_cnt;
        return s;
    endfunction

endpackage

// File: rtl/aes_avalon_block_bridge_if.sv
// Avalon-MM slave bus plus the block valid/ready streams to and from the cipher core.
interface aes_avalon_block_bridge_if #(
    parameter int unsigned BLOCK_W = 128
);
    logic               chipselect;
    logic [1:0]         address;
    logic               read;
    logic               write;
    logic [31:0]        writedata;
    logic [31:0]        readdata;
    logic [BLOCK_W-1:0] blk_in_data;
    logic               blk_in_valid;
    logic               blk_in_ready;
    logic [BLOCK_W-1:0] blk_out_data;
    logic               blk_out_valid;
    logic               blk_out_ready;

    // Bridge side.
    modport slave (
        input  chipselect, address, read, write, writedata,
        input  blk_in_ready, blk_out_data, blk_out_valid,
        output readdata, blk_in_data, blk_in_valid, blk_out_ready
    );

    // Host and core side.
    modport master (
        output chipselect, address, read, write, writedata,
        output blk_in_ready, blk_out_data, blk_out_valid,
        input  readdata, blk_in_data, blk_in_valid, blk_out_ready
    );
endinterface

// File: rtl/aes_avb_sync_fifo.sv
// Single-clock FIFO with occupancy count; reads zero at the head while empty.
module aes_avb_sync_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == CntW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = empty ? '0 : mem[rd_ptr_q];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok && !clear && !reset) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/aes_avalon_block_bridge.sv
// Avalon-MM to block-cipher bridge: word assembly, input/output block FIFOs, status.
// Define AES_AVB_IRQ_EN to add the registered irq output and CTRL irq enable bit.
module aes_avalon_block_bridge
    import aes_avb_pkg::*;
#(
    parameter int unsigned BLOCK_W   = 128,
    parameter int unsigned IN_DEPTH  = 4,
    parameter int unsigned OUT_DEPTH = 4
) (
    input logic clock,
    input logic reset,
`ifdef AES_AVB_IRQ_EN
    output logic irq,
`endif
    aes_avalon_block_bridge_if.slave bus
);

    localparam int unsigned WORDS   = BLOCK_W / 32;
    localparam int unsigned IdxW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned InCntW  = $clog2(IN_DEPTH + 1);
    localparam int unsigned OutCntW = $clog2(OUT_DEPTH + 1);

    logic               wr_acc, rd_acc;
    logic               soft_clr, data_in_wr, data_out_rd, status_wr;
    logic [BLOCK_W-1:0] asm_q, asm_d;
    logic [IdxW-1:0]    wr_idx_q, wr_idx_d;
    logic [IdxW-1:0]    rd_idx_q, rd_idx_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               in_push, in_pop, in_full, in_empty;
    logic               out_push, out_pop, out_full, out_empty;
    logic [InCntW-1:0]  in_count;
    logic [OutCntW-1:0] out_count;
    logic [BLOCK_W-1:0] out_head;
    logic [31:0]        head_word;
    logic [31:0]        status_word;
    logic [31:0]        rdata;

    assign wr_acc      = bus.chipselect && bus.write;
    assign rd_acc      = bus.chipselect && bus.read;
    assign soft_clr    = wr_acc && (bus.address == AddrCtrl) && bus.writedata[CtrlClrBit];
    assign status_wr   = wr_acc && (bus.address == AddrStatus);
    assign data_in_wr  = wr_acc && (bus.address == AddrDataIn);
    assign data_out_rd = rd_acc && (bus.address == AddrDataOut);

    assign in_pop            = !in_empty && bus.blk_in_ready;
    assign bus.blk_in_valid  = !in_empty;
    assign out_push          = bus.blk_out_valid && !out_full;
    assign bus.blk_out_ready = !out_full;

    aes_avb_sync_fifo #(
        .WIDTH(BLOCK_W),
        .DEPTH(IN_DEPTH)
    ) u_in_fifo (
        .clock    (clock),
        .reset    (reset),
        .clear    (soft_clr),
        .push     (in_push),
        .push_data(asm_d),
        .pop      (in_pop),
        .pop_data (bus.blk_in_data),
        .full     (in_full),
        .empty    (in_empty),
        .count    (in_count)
    );

    aes_avb_sync_fifo #(
        .WIDTH(BLOCK_W),
        .DEPTH(OUT_DEPTH)
    ) u_out_fifo (
        .clock    (clock),
        .reset    (reset),
        .clear    (soft_clr),
        .push     (out_push),
        .push_data(bus.blk_out_data),
        .pop      (out_pop),
        .pop_data (out_head),
        .full     (out_full),
        .empty    (out_empty),
        .count    (out_count)
    );

    // Word 0 is the most significant word of a block, on both directions.
    always_comb begin
        asm_d    = asm_q;
        wr_idx_d = wr_idx_q;
        in_push  = 1'b0;
        if (data_in_wr) begin
            for (int k = 0; k < int'(WORDS); k++) begin
                if (wr_idx_q == IdxW'(k)) asm_d[BLOCK_W-1-32*k -: 32] = bus.writedata;
            end
            if (wr_idx_q == IdxW'(WORDS - 1)) begin
                in_push  = 1'b1;
                wr_idx_d = '0;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end
        if (soft_clr) wr_idx_d = '0;
    end

    always_comb begin
        head_word = '0;
        for (int k = 0; k < int'(WORDS); k++) begin
            if (rd_idx_q == IdxW'(k)) head_word = out_head[BLOCK_W-1-32*k -: 32];
        end
    end

    always_comb begin
        rd_idx_d = rd_idx_q;
        out_pop  = 1'b0;
        if (data_out_rd && !out_empty) begin
            if (rd_idx_q == IdxW'(WORDS - 1)) begin
                out_pop  = 1'b1;
                rd_idx_d = '0;
            end else begin
                rd_idx_d = rd_idx_q + 1'b1;
            end
        end
        if (soft_clr) rd_idx_d = '0;
    end

    // Sticky flags: set beats write-1-to-clear, soft clear beats both.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (status_wr && bus.writedata[StOvfBit]) ovf_d = 1'b0;
        if (status_wr && bus.writedata[StUnfBit]) unf_d = 1'b0;
        if (in_push && in_full && !in_pop)        ovf_d = 1'b1;
        if (data_out_rd && out_empty)             unf_d = 1'b1;
        if (soft_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    assign status_word = pack_status(in_full, in_empty, out_full, out_empty, ovf_q, unf_q,
                                     8'(in_count), 8'(out_count));

    always_comb begin
        rdata = '0;
        if (rd_acc && !reset) begin
            case (bus.address)
                AddrStatus:  rdata = status_word;
                AddrDataOut: rdata = out_empty ? '0 : head_word;
                default:     rdata = '0;
            endcase
        end
    end

    assign bus.readdata = rdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            asm_q    <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            asm_q    <= asm_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

`ifdef AES_AVB_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q;

    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_acc && (bus.address == AddrCtrl)) irq_en_d = bus.writedata[CtrlIrqEnBit];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_q && !out_empty;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_aes_avalon_block_bridge.sv
// Bench for aes_avalon_block_bridge: directed literal checks plus randomized traffic
// compared every cycle against a queue-based model of the bridge.
module tb_aes_avalon_block_bridge;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    aes_avalon_block_bridge_if #(.BLOCK_W(128)) bus ();
`ifdef AES_AVB_IRQ_EN
    logic irq;
`endif

    aes_avalon_block_bridge #(
        .BLOCK_W  (128),
        .IN_DEPTH (4),
        .OUT_DEPTH(4)
    ) dut (
        .clock(clock),
        .reset(reset),
`ifdef AES_AVB_IRQ_EN
        .irq  (irq),
`endif
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;
    bit model_on = 1'b0;

    // Reference model state.
    logic [127:0] in_q[$];
    logic [127:0] out_q[$];
    logic [31:0]  asm_w[4];
    int           wr_idx = 0;
    int           rd_idx = 0;
    bit           ovf = 1'b0, unf = 1'b0, irq_en = 1'b0, irq_exp = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int s;
        s = in_q.size() * 256 + out_q.size() * 65536;
        if (in_q.size() == 4)  s += 1;
        if (in_q.size() == 0)  s += 2;
        if (out_q.size() == 4) s += 4;
        if (out_q.size() == 0) s += 8;
        if (ovf)               s += 16;
        if (unf)               s += 32;
        return 32'(s);
    endfunction

    function automatic logic [31:0] exp_read();
        if (bus.address == 2'd1) return exp_status();
        if (bus.address == 2'd3 && out_q.size() != 0) return 32'(out_q[0] >> (32 * (3 - rd_idx)));
        return 32'd0;
    endfunction

    task automatic model_step();
        bit in_pop, out_push, out_pop, push_ok, acc_wr, acc_rd, clr;
        logic [127:0] blk;
        acc_wr = bus.chipselect && bus.write;
        acc_rd = bus.chipselect && bus.read;
        if (reset) begin
            in_q.delete();
            out_q.delete();
            wr_idx = 0; rd_idx = 0; ovf = 0; unf = 0; irq_en = 0; irq_exp = 0;
            return;
        end
        irq_exp  = irq_en && (out_q.size() != 0);
        in_pop   = (in_q.size() != 0) && bus.blk_in_ready;
        out_push = bus.blk_out_valid && (out_q.size() < 4);
        clr      = acc_wr && bus.address == 2'd0 && bus.writedata[0];
        if (acc_wr && bus.address == 2'd0) irq_en = bus.writedata[1];
        if (clr) begin
            in_q.delete();
            out_q.delete();
            wr_idx = 0; rd_idx = 0; ovf = 0; unf = 0;
            return;
        end
        push_ok = 1'b0;
        out_pop = 1'b0;
        blk     = '0;
        if (acc_wr && bus.address == 2'd2) begin
            asm_w[wr_idx] = bus.writedata;
            if (wr_idx == 3) begin
                blk = {asm_w[0], asm_w[1], asm_w[2], asm_w[3]};
                push_ok = (in_q.size() < 4) || in_pop;
                if (!push_ok) ovf = 1'b1;
                wr_idx = 0;
            end else begin
                wr_idx++;
            end
        end
        if (acc_wr && bus.address == 2'd1) begin
            if (bus.writedata[4]) ovf = 1'b0;
            if (bus.writedata[5]) unf = 1'b0;
        end
        if (acc_rd && bus.address == 2'd3) begin
            if (out_q.size() == 0) unf = 1'b1;
            else if (rd_idx == 3) begin out_pop = 1'b1; rd_idx = 0; end
            else rd_idx++;
        end
        if (in_pop)   void'(in_q.pop_front());
        if (push_ok)  in_q.push_back(blk);
        if (out_pop)  void'(out_q.pop_front());
        if (out_push) out_q.push_back(bus.blk_out_data);
    endtask

    // Compare the DUT against the model, then advance the model over the coming edge.
    always @(negedge clock) begin
        if (model_on) begin
            check("in_valid", bus.blk_in_valid, in_q.size() != 0);
            if (in_q.size() != 0) check("in_data", bus.blk_in_data, in_q[0]);
            check("out_ready", bus.blk_out_ready, out_q.size() < 4);
            if (!reset && bus.chipselect && bus.read) check("readdata", bus.readdata, exp_read());
`ifdef AES_AVB_IRQ_EN
            check("irq", irq, irq_exp);
`endif
        end
        model_step();
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.read = 1'b0;
        bus.address = a; bus.writedata = d;
        tick();
        bus.chipselect = 1'b0; bus.write = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.write = 1'b0; bus.address = a;
        @(negedge clock);
        d = bus.readdata;
        tick();
        bus.chipselect = 1'b0; bus.read = 1'b0;
    endtask

    task automatic core_push(input logic [127:0] d);
        bus.blk_out_valid = 1'b1; bus.blk_out_data = d;
        tick();
        bus.blk_out_valid = 1'b0;
    endtask

    task automatic drain_in(input int n);
        bus.blk_in_ready = 1'b1;
        repeat (n) tick();
        bus.blk_in_ready = 1'b0;
    endtask

    task automatic write_block(input int b);
        for (int k = 0; k < 4; k++) bus_wr(2'd2, 32'(256 * (b + 1) + k));
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] wd;
        bit slow;
        bus.chipselect = 0; bus.address = 0; bus.read = 0; bus.write = 0; bus.writedata = 0;
        bus.blk_in_ready = 0; bus.blk_out_data = '0; bus.blk_out_valid = 0;
        repeat (3) tick();
        reset = 1'b0;
        model_on = 1'b1;

        // Reset state.
        check("rst_in_valid", bus.blk_in_valid, 0);
        check("rst_in_data", bus.blk_in_data, 0);
        check("rst_out_ready", bus.blk_out_ready, 1);
        check("rst_readdata", bus.readdata, 0);
        bus_rd(2'd1, rd);
        check("rst_status", rd, 32'h0000_000A);

        // Block write.
        bus_wr(2'd2, 32'h0011_2233); bus_wr(2'd2, 32'h4455_6677);
        bus_wr(2'd2, 32'h8899_AABB);
        check("pre_last_valid", bus.blk_in_valid, 0);
        bus_wr(2'd2, 32'hCCDD_EEFF);
        check("blk_valid", bus.blk_in_valid, 1);
        check("blk_data", bus.blk_in_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        bus_rd(2'd1, rd);
        check("blk_status", rd, 32'h0000_0108);

        // Output readback.
        core_push(128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3);
        bus_rd(2'd3, rd); check("rb_w0", rd, 32'hA0A1_A2A3);
        bus_rd(2'd3, rd); check("rb_w1", rd, 32'hB0B1_B2B3);
        bus_rd(2'd3, rd); check("rb_w2", rd, 32'hC0C1_C2C3);
        bus_rd(2'd3, rd); check("rb_w3", rd, 32'hD0D1_D2D3);
        bus_rd(2'd1, rd); check("rb_status", rd, 32'h0000_0108);
        drain_in(1);

        // Overflow.
        for (int b = 0; b < 5; b++) write_block(b);
        bus_rd(2'd1, rd); check("ovf_status", rd, 32'h0000_0419);
        check("ovf_head", bus.blk_in_data, 128'h00000100_00000101_00000102_00000103);
        bus_wr(2'd1, 32'h10);
        bus_rd(2'd1, rd); check("ovf_w1c", rd, 32'h0000_0409);
        drain_in(4);

        // Underflow.
        bus_rd(2'd3, rd); check("unf_data", rd, 0);
        bus_rd(2'd1, rd); check("unf_status", rd, 32'h0000_002A);
        core_push(128'h11111111_22222222_33333333_44444444);
        bus_rd(2'd3, rd); check("unf_w0", rd, 32'h1111_1111);
        bus_rd(2'd3, rd); bus_rd(2'd3, rd); bus_rd(2'd3, rd);
        check("unf_w3", rd, 32'h4444_4444);
        bus_wr(2'd1, 32'h20);
        bus_rd(2'd1, rd); check("unf_w1c", rd, 32'h0000_000A);

        // Push and pop together on a full input FIFO.
        for (int b = 10; b < 14; b++) write_block(b);
        for (int k = 0; k < 3; k++) bus_wr(2'd2, 32'(256 * 15 + k));
        bus.blk_in_ready = 1'b1;
        bus_wr(2'd2, 32'(256 * 15 + 3));
        bus.blk_in_ready = 1'b0;
        bus_rd(2'd1, rd); check("sim_status", rd, 32'h0000_0409);
        check("sim_head", bus.blk_in_data, 128'h00000C00_00000C01_00000C02_00000C03);
        drain_in(4);

        // Soft clear.
        bus_wr(2'd2, 32'hAAAA_0000); bus_wr(2'd2, 32'hAAAA_0001);
        core_push(128'h5);
        bus_rd(2'd1, rd); check("clr_pre", rd, 32'h0001_0002);
        bus_wr(2'd0, 32'h1);
        bus_rd(2'd1, rd); check("clr_status", rd, 32'h0000_000A);
        bus_wr(2'd2, 32'hDEAD_BEEF); bus_wr(2'd2, 32'h0123_4567);
        bus_wr(2'd2, 32'h89AB_CDEF); bus_wr(2'd2, 32'hFEED_FACE);
        check("clr_valid", bus.blk_in_valid, 1);
        check("clr_block", bus.blk_in_data, 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE);
        drain_in(1);
`ifdef AES_AVB_IRQ_EN
        bus_wr(2'd0, 32'h2);
        core_push(128'h7);
        tick();
        check("irq_set", irq, 1);
        bus_wr(2'd0, 32'h1);
`endif

        // Randomized traffic, with occasional resets mid-block.
        slow = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            int op;
            if (c % 600 == 0) slow = !slow;
            op = int'($urandom_range(0, 11));
            bus.chipselect = ($urandom_range(0, 15) != 0);
            bus.read = 1'b0; bus.write = 1'b0;
            bus.writedata = $urandom();
            case (op)
                0, 1, 2: begin bus.write = 1'b1; bus.address = 2'd2; end
                3, 4:    begin bus.read = 1'b1; bus.address = 2'd3; end
                5:       begin bus.read = 1'b1; bus.address = 2'd1; end
                6:       begin bus.read = 1'b1; bus.address = 2'd2; end
                7:       begin bus.write = 1'b1; bus.address = 2'd1; end
                8: begin
                    wd = $urandom();
                    wd[0] = ($urandom_range(0, 7) == 0);
                    bus.writedata = wd;
                    bus.write = 1'b1; bus.address = 2'd0;
                end
                9:       begin bus.write = 1'b1; bus.address = 2'd3; end
                default: bus.chipselect = 1'b0;
            endcase
            bus.blk_in_ready  = slow ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
            bus.blk_out_valid = ($urandom_range(0, 1) == 1);
            bus.blk_out_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            reset = ($urandom_range(0, 399) == 0);
            tick();
        end
        bus.chipselect = 0; bus.read = 0; bus.write = 0;
        bus.blk_in_ready = 0; bus.blk_out_valid = 0; reset = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_avalon_block_bridge.md
# aes_avalon_block_bridge

Parametrised Avalon-MM slave that sits between the Nios II data master and a block cipher core (AES-GCM encryptor). It assembles 32-bit bus writes into `BLOCK_W`-bit blocks and buffers them in an input FIFO. Those blocks are handed to the core over a valid/ready handshake. Core results are captured in an output FIFO and served back to software one word at a time, with status counts and sticky error flags.

## Interface
- `BLOCK_W`, 128: core block width in bits; must be a multiple of 32 and at least 32; `WORDS = BLOCK_W/32`.
- `IN_DEPTH`, 4: input FIFO depth in blocks; power of two, at least 2.
- `OUT_DEPTH`, 4: output FIFO depth in blocks; power of two, at least 2.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `chipselect`  in  1  Avalon slave select.
- `address`  in  2  word address: 0 CTRL, 1 STATUS, 2 DATA_IN, 3 DATA_OUT.
- `read`  in  1  Avalon read strobe.
- `write`  in  1  Avalon write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  read data; combinational, read latency 0.
- `blk_in_data`  out  BLOCK_W  head of input FIFO.
- `blk_in_valid`  out  1  input FIFO not empty.
- `blk_in_ready`  in  1  core accepts a block.
- `blk_out_data`  in  BLOCK_W  core result.
- `blk_out_valid`  in  1  core result valid.
- `blk_out_ready`  out  1  output FIFO not full.

## Operation
- An access is a cycle with `chipselect` high and `read` or `write` high. All side effects occur at that cycle's clock edge.
- CTRL write, bit0 = 1 (soft clear):
  - empties both FIFOs;
  - zeroes the assembly and read word indexes;
  - clears the sticky flags.
  - Soft clear takes priority over any same-cycle push or pop.
- STATUS read:
  - bit0 in_full, bit1 in_empty, bit2 out_full, bit3 out_empty;
  - bit4 OVF (sticky), bit5 UNF (sticky);
  - bits[15:8] in_count, bits[23:16] out_count.
- STATUS write is write-1-to-clear on bits 4 and 5.
- DATA_IN write:
  - Word k (k = 0..WORDS-1) lands in bits `[BLOCK_W-1-32k -: 32]` of the assembly register. Word 0 is most significant.
  - The word index increments on each write.
  - On word WORDS-1, the assembled block is pushed and the index wraps to 0.
  - If the input FIFO is full and the core does not pop in the same cycle, the block is dropped, OVF is set, and the index still wraps.
- DATA_OUT read:
  - Returns word `rd_idx` of the output FIFO head, using the same ordering as DATA_IN.
  - `rd_idx` increments on each read. After word WORDS-1 the head is popped and `rd_idx` wraps to 0.
  - A read while the output FIFO is empty returns 0, sets UNF, and leaves `rd_idx` unchanged.
- Reads at other addresses return 0. Writes at other addresses are ignored.
- Core side:
  - The input FIFO pops when `blk_in_valid && blk_in_ready`.
  - The output FIFO pushes when `blk_out_valid && blk_out_ready`.
- FIFO rule: a push and a pop in the same cycle on a full FIFO are both accepted and the count is unchanged. A pop on an empty FIFO is impossible because valid is low.

## Timing
- Reset values:
  - `readdata` = 0, `blk_in_valid` = 0, `blk_in_data` = 0;
  - `blk_out_ready` = 1;
  - all counts, indexes, sticky flags and the assembly register = 0.
- Write to core latency: after the last DATA_IN write at edge N, `blk_in_valid` is 1 in cycle N+1.
- Core to read latency: after a core push at edge N, STATUS out_empty reads 0 in cycle N+1.
- Reset asserted mid-block discards any partially assembled block and any partially read block.

## Configuration
- `AES_AVB_IRQ_EN` defined:
  - adds output port `irq` (1 bit);
  - CTRL bit1 becomes IRQ enable (reset 0);
  - `irq = ctrl_irq_en && !out_empty`, registered, so it follows the condition by one cycle.
- `AES_AVB_IRQ_EN` undefined:
  - no `irq` port;
  - CTRL bit1 is ignored.

## Structure
- Shared package `aes_avb_pkg`:
  - address constants;
  - STATUS bit positions;
  - CTRL bit positions.
- Sub-module `aes_avb_sync_fifo`, parameters width and depth:
  - ports push/pop/full/empty/count;
  - instantiated twice, once for the input FIFO and once for the output FIFO.
- Top-level contents:
  - word assembly;
  - read word indexing;
  - register decode;
  - sticky flags.

## Test plan
- Block write, BLOCK_W=128:
  - Stimulus: hold `blk_in_ready` = 0; write DATA_IN 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF.
  - Response: `blk_in_data` = 0x00112233_44556677_8899AABB_CCDDEEFF and `blk_in_valid` = 1 one cycle after the 4th write; STATUS in_count = 1.
- Output readback:
  - Stimulus: core pushes 0xA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3; then read DATA_OUT four times.
  - Response: reads return 0xA0A1A2A3, 0xB0B1B2B3, 0xC0C1C2C3, 0xD0D1D2D3 in order; STATUS out_empty = 1 afterwards.
- Overflow:
  - Stimulus: with `blk_in_ready` = 0, write 5 complete blocks (IN_DEPTH = 4).
  - Response: in_count = 4, OVF = 1, FIFO head is still block 1; a STATUS write of 0x10 clears OVF.
- Underflow:
  - Stimulus: read DATA_OUT with the output FIFO empty.
  - Response: returns 0; UNF = 1; a following core push is then read correctly from word 0.
- Full simultaneity:
  - Stimulus: input FIFO full; final DATA_IN word written in the same cycle as `blk_in_ready` = 1.
  - Response: count stays 4, OVF stays 0.
- Soft clear and IRQ:
  - Stimulus: 2 words written and 1 output block pending; CTRL write 0x1.
  - Response: both FIFOs are empty; the next 4 DATA_IN writes form a fresh block.
  - With `AES_AVB_IRQ_EN` defined: CTRL = 0x2 plus a core push gives `irq` = 1.
